// File: rtl/arm_motor_cmd_dispatcher_pkg.sv
// Shared constants, FSM encoding and a frame byte accessor for the arm/motor command dispatcher.
package arm_motor_cmd_dispatcher_pkg;

  localparam logic [7:0] HDR0    = 8'h55;
  localparam logic [7:0] HDR1    = 8'hA5;
  localparam logic [7:0] TAIL    = 8'hF0;
  localparam logic [7:0] ARM_CMD = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM_GO,
    ST_ARM_WAIT,
    ST_MOT_GO,
    ST_MOT_WAIT,
    ST_DONE
  } state_t;

  // Byte n of a frame; b0 sits in the top byte [79:72].
  function automatic logic [7:0] frame_byte(input logic [79:0] f, input logic [31:0] n);
    logic [79:0] s;
    s = f >> (8 * (9 - n));
    return s[7:0];
  endfunction

endpackage

// File: rtl/arm_motor_cmd_dispatcher_assembler.sv
// Host frame assembler: header/tail validation, inter-byte gap timer and 80-bit frame capture.
module cmd_frame_assembler
  import arm_motor_cmd_dispatcher_pkg::*;
#(
  parameter int GAP_TIMEOUT = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [79:0] frame,
  output logic        frame_valid,
  output logic        frame_err
);

  localparam logic [31:0] GAP_LAST = 32'(GAP_TIMEOUT - 1);

  logic [3:0]  idx;
  logic [3:0]  idx_n;
  logic [31:0] gap_cnt;
  logic [71:0] shift;
  logic        err_n;

  // frame_valid is combinational with the tail byte so the holding reg loads on that same edge.
  always_comb begin
    idx_n       = idx;
    err_n       = 1'b0;
    frame_valid = 1'b0;
    frame       = {shift, rx_data};
    if (!en) begin
      idx_n = 4'd0;
    end else if (rx_done) begin
      case (idx)
        4'd0: begin
          if (rx_data == HDR0) idx_n = 4'd1;
        end
        4'd1: begin
          if (rx_data == HDR1) begin
            idx_n = 4'd2;
          end else begin
            err_n = 1'b1;
            idx_n = (rx_data == HDR0) ? 4'd1 : 4'd0;
          end
        end
        4'd9: begin
          idx_n = 4'd0;
          if (rx_data == TAIL) frame_valid = 1'b1;
          else                 err_n       = 1'b1;
        end
        default: idx_n = idx + 4'd1;
      endcase
    end else if (idx != 4'd0 && gap_cnt == GAP_LAST) begin
      err_n = 1'b1;
      idx_n = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= 4'd0;
      gap_cnt   <= 32'd0;
      frame_err <= 1'b0;
    end else begin
      idx       <= idx_n;
      frame_err <= err_n;
      if (rx_done || idx == 4'd0 || !en) gap_cnt <= 32'd0;
      else                               gap_cnt <= gap_cnt + 32'd1;
    end
  end

  // The shift reg always holds the most recent bytes; only idx decides when they form a frame.
  always_ff @(posedge clk) begin
    if (en && rx_done) shift <= {shift[63:0], rx_data};
  end

endmodule

// File: rtl/arm_motor_cmd_dispatcher.sv
// Routes validated host frames to the arm UART TX or as I2C register writes to the motor engine.
module arm_motor_cmd_dispatcher
  import arm_motor_cmd_dispatcher_pkg::*;
#(
  parameter int GAP_TIMEOUT  = 500000,
  parameter int DONE_TIMEOUT = 2000000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        EN,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [79:0] arm_data,
  output logic        arm_send_en,
  input  logic        arm_tx_done,
  output logic        i2c_wr_req,
  output logic [7:0]  i2c_reg_addr,
  output logic [7:0]  i2c_wr_data,
  input  logic        i2c_rw_done,
  output logic        busy,
  output logic        frame_err,
  output logic        overrun,
  output logic        timeout_err
);

  localparam logic [31:0] WAIT_LAST = 32'(DONE_TIMEOUT - 1);

  logic [79:0] asm_frame;
  logic        asm_valid;
  logic [79:0] hold_frame;
  logic        hold_full;
  logic [79:0] act_frame;
  state_t      state, state_n;
  logic [1:0]  k, k_n;
  logic [31:0] wait_cnt;
  logic [31:0] pair_idx;
  logic [7:0]  pair_addr, pair_data;
  logic        take, wait_expired;
  logic [79:0] arm_data_n;
  logic        arm_send_n, i2c_req_n, to_n;
  logic [7:0]  addr_n, data_n;

  cmd_frame_assembler #(
    .GAP_TIMEOUT(GAP_TIMEOUT)
  ) u_asm (
    .clk        (Clk),
    .rst        (Rst),
    .en         (EN),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .frame      (asm_frame),
    .frame_valid(asm_valid),
    .frame_err  (frame_err)
  );

  // Holding reg frees up when the FSM takes the frame, so one frame can queue behind the active one.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hold_full <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (asm_valid && (!hold_full || take)) hold_full <= 1'b1;
      else if (asm_valid)                    overrun   <= 1'b1;
      else if (take)                         hold_full <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (asm_valid && (!hold_full || take)) hold_frame <= asm_frame;
    if (take)                              act_frame  <= hold_frame;
  end

  assign busy         = (state != ST_IDLE) || hold_full;
  assign pair_idx     = 32'd2 + {29'd0, k, 1'b0};
  assign pair_addr    = frame_byte(act_frame, pair_idx);
  assign pair_data    = frame_byte(act_frame, pair_idx + 32'd1);
  assign wait_expired = (wait_cnt == WAIT_LAST);

  always_comb begin
    state_n    = state;
    k_n        = k;
    take       = 1'b0;
    arm_send_n = 1'b0;
    i2c_req_n  = 1'b0;
    to_n       = 1'b0;
    arm_data_n = arm_data;
    addr_n     = i2c_reg_addr;
    data_n     = i2c_wr_data;
    case (state)
      ST_IDLE: begin
        if (hold_full && EN) begin
          take    = 1'b1;
          k_n     = 2'd0;
          state_n = (frame_byte(hold_frame, 32'd2) == ARM_CMD) ? ST_ARM_GO : ST_MOT_GO;
        end
      end
      ST_ARM_GO: begin
        arm_send_n = 1'b1;
        arm_data_n = act_frame;
        state_n    = ST_ARM_WAIT;
      end
      ST_ARM_WAIT: begin
        if (arm_tx_done) begin
          state_n = ST_DONE;
        end else if (wait_expired) begin
          to_n    = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_MOT_GO: begin
        if (pair_addr == 8'h00) begin
          if (k == 2'd2) state_n = ST_DONE;
          else           k_n     = k + 2'd1;
        end else begin
          i2c_req_n = 1'b1;
          addr_n    = pair_addr;
          data_n    = pair_data;
          state_n   = ST_MOT_WAIT;
        end
      end
      ST_MOT_WAIT: begin
        if (i2c_rw_done) begin
          if (k == 2'd2) begin
            state_n = ST_DONE;
          end else begin
            k_n     = k + 2'd1;
            state_n = ST_MOT_GO;
          end
        end else if (wait_expired) begin
          to_n    = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state        <= ST_IDLE;
      k            <= 2'd0;
      wait_cnt     <= 32'd0;
      arm_data     <= 80'd0;
      arm_send_en  <= 1'b0;
      i2c_wr_req   <= 1'b0;
      i2c_reg_addr <= 8'd0;
      i2c_wr_data  <= 8'd0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_n;
      k            <= k_n;
      arm_data     <= arm_data_n;
      arm_send_en  <= arm_send_n;
      i2c_wr_req   <= i2c_req_n;
      i2c_reg_addr <= addr_n;
      i2c_wr_data  <= data_n;
      timeout_err  <= to_n;
      // Counter is zero on the first WAIT cycle because the preceding GO state holds it clear.
      if (state == ST_ARM_WAIT || state == ST_MOT_WAIT) wait_cnt <= wait_cnt + 32'd1;
      else                                               wait_cnt <= 32'd0;
    end
  end

endmodule

// File: tb/tb_arm_motor_cmd_dispatcher.sv
// Directed bench for arm_motor_cmd_dispatcher with auto-responding arm/I2C done models.
module tb_arm_motor_cmd_dispatcher;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        EN = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic [79:0] arm_data;
  logic        arm_send_en;
  logic        arm_tx_done = 1'b0;
  logic        i2c_wr_req;
  logic [7:0]  i2c_reg_addr;
  logic [7:0]  i2c_wr_data;
  logic        i2c_rw_done = 1'b0;
  logic        busy, frame_err, overrun, timeout_err;

  int checks = 0;
  int failures = 0;

  bit auto_arm = 1'b1;
  bit auto_i2c = 1'b1;
  int cyc = 0, arm_n = 0, wr_n = 0, ferr_n = 0, ovr_n = 0, to_n = 0, viol_n = 0;
  int wr_cyc = 0, to_cyc = 0, done_cyc = 0, fall_cyc = 0, arm_dly = 0, i2c_dly = 0;
  bit outstanding = 1'b0;
  logic prev_busy = 1'b0;
  logic [79:0] arm_last = 80'd0;
  logic [15:0] wr_log [64];

  arm_motor_cmd_dispatcher #(.GAP_TIMEOUT(50), .DONE_TIMEOUT(100)) dut (
    .Clk(Clk), .Rst(Rst), .EN(EN), .rx_data(rx_data), .rx_done(rx_done),
    .arm_data(arm_data), .arm_send_en(arm_send_en), .arm_tx_done(arm_tx_done),
    .i2c_wr_req(i2c_wr_req), .i2c_reg_addr(i2c_reg_addr), .i2c_wr_data(i2c_wr_data),
    .i2c_rw_done(i2c_rw_done), .busy(busy), .frame_err(frame_err), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  always #5 Clk = ~Clk;

  // Monitor and done responders, all sampled on the falling edge.
  always @(negedge Clk) begin
    cyc++;
    arm_tx_done = 1'b0;
    i2c_rw_done = 1'b0;
    if (Rst) begin arm_dly = 0; i2c_dly = 0; outstanding = 1'b0; end
    if (prev_busy && !busy) fall_cyc = cyc;
    prev_busy = busy;
    if (frame_err) ferr_n++;
    if (overrun) ovr_n++;
    if (timeout_err) begin to_n++; to_cyc = cyc; outstanding = 1'b0; end
    if (arm_send_en) begin
      arm_n++; arm_last = arm_data;
      if (auto_arm) arm_dly = 3;
    end else if (arm_dly > 0) begin
      arm_dly--;
      if (arm_dly == 0) begin arm_tx_done = 1'b1; done_cyc = cyc; end
    end
    if (i2c_wr_req) begin
      if (outstanding) viol_n++;
      outstanding = 1'b1;
      if (wr_n < 64) wr_log[wr_n] = {i2c_reg_addr, i2c_wr_data};
      wr_n++; wr_cyc = cyc;
      if (auto_i2c) i2c_dly = 3;
    end else if (i2c_dly > 0) begin
      i2c_dly--;
      if (i2c_dly == 0) begin i2c_rw_done = 1'b1; outstanding = 1'b0; end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(negedge Clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge Clk);
    rx_data = b; rx_done = 1'b1;
    @(negedge Clk);
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [79:0] f);
    logic [79:0] s;
    s = f;
    for (int i = 0; i < 10; i++) begin send_byte(s[79:72]); s = s << 8; end
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n;
    n = 0;
    do begin @(negedge Clk); #1; n++; end while (busy && n < max);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL %s_idle: busy=%b after %0d cycles, expected 0", tag, busy, n); end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick(3);
    checks++; if (arm_data !== 80'd0) begin failures++; $display("FAIL reset_arm_data: got %h expected 0", arm_data); end
    checks++; if ({arm_send_en, i2c_wr_req, busy, frame_err, overrun, timeout_err} !== 6'b0) begin
      failures++; $display("FAIL reset_flags: got %b expected 000000", {arm_send_en, i2c_wr_req, busy, frame_err, overrun, timeout_err}); end
    checks++; if ({i2c_reg_addr, i2c_wr_data} !== 16'h0000) begin failures++; $display("FAIL reset_i2c: got %h expected 0000", {i2c_reg_addr, i2c_wr_data}); end
    @(negedge Clk); Rst = 1'b0;
    tick(2);
  endtask

  task automatic test_arm();
    int a0, w0;
    a0 = arm_n; w0 = wr_n;
    send_frame(80'h55A5000080000000_00F0);
    tick(1);
    checks++; if (arm_n !== a0) begin failures++; $display("FAIL arm_latency_early: strobes=%0d expected %0d", arm_n - a0, 0); end
    tick(1);
    checks++; if (arm_n !== a0 + 1) begin failures++; $display("FAIL arm_latency: strobes=%0d expected %0d", arm_n - a0, 1); end
    checks++; if (arm_last !== 80'h55A5000080000000_00F0) begin failures++; $display("FAIL arm_data: got %h expected 55a500008000000000f0", arm_last); end
    wait_idle(50, "arm");
    checks++; if (fall_cyc - done_cyc !== 2) begin failures++; $display("FAIL arm_busy_fall: got %0d cycles expected 2", fall_cyc - done_cyc); end
    checks++; if (arm_n !== a0 + 1 || wr_n !== w0) begin failures++; $display("FAIL arm_count: arm=%0d wr=%0d expected 1 0", arm_n - a0, wr_n - w0); end
  endtask

  task automatic test_motor();
    int w0, v0;
    w0 = wr_n; v0 = viol_n;
    send_frame(80'h55A5340435050607_08F0);
    wait_idle(100, "motor");
    checks++; if (wr_n !== w0 + 3) begin failures++; $display("FAIL motor_count: got %0d expected 3", wr_n - w0); end
    checks++; if ({wr_log[w0], wr_log[w0+1], wr_log[w0+2]} !== 48'h3404_3505_0607) begin
      failures++; $display("FAIL motor_pairs: got %h expected 340435050607", {wr_log[w0], wr_log[w0+1], wr_log[w0+2]}); end
    checks++; if (viol_n !== v0) begin failures++; $display("FAIL motor_order: req before done %0d times expected 0", viol_n - v0); end
  endtask

  task automatic test_skip();
    int a0, w0;
    a0 = arm_n; w0 = wr_n;
    send_frame(80'h55A5003400000000_00F0);
    wait_idle(50, "skip_arm");
    checks++; if (arm_n !== a0 + 1 || wr_n !== w0) begin failures++; $display("FAIL skip_arm_route: arm=%0d wr=%0d expected 1 0", arm_n - a0, wr_n - w0); end
    send_frame(80'h55A5100100991202_00F0);
    wait_idle(100, "skip_mot");
    checks++; if (wr_n !== w0 + 2) begin failures++; $display("FAIL skip_count: got %0d expected 2", wr_n - w0); end
    checks++; if ({wr_log[w0], wr_log[w0+1]} !== 32'h1001_1202) begin failures++; $display("FAIL skip_pairs: got %h expected 10011202", {wr_log[w0], wr_log[w0+1]}); end
  endtask

  task automatic test_frame_err();
    int a0, w0, e0;
    a0 = arm_n; w0 = wr_n; e0 = ferr_n;
    send_frame(80'h5577000000000000_00F0);
    tick(2);
    checks++; if (ferr_n !== e0 + 1) begin failures++; $display("FAIL ferr_hdr1: got %0d expected 1", ferr_n - e0); end
    send_frame(80'h55A5000000000000_00E0);
    tick(2);
    checks++; if (ferr_n !== e0 + 2) begin failures++; $display("FAIL ferr_tail: got %0d expected 2", ferr_n - e0); end
    checks++; if (arm_n !== a0 || wr_n !== w0 || busy !== 1'b0) begin
      failures++; $display("FAIL ferr_no_strobe: arm=%0d wr=%0d busy=%b expected 0 0 0", arm_n - a0, wr_n - w0, busy); end
    send_byte(8'h55);
    send_frame(80'h55A5200100000000_00F0);
    wait_idle(100, "ferr_recheck");
    checks++; if (ferr_n !== e0 + 3 || wr_n !== w0 + 1 || wr_log[w0] !== 16'h2001) begin
      failures++; $display("FAIL ferr_recheck: ferr=%0d wr=%0d pair=%h expected 3 1 2001", ferr_n - e0, wr_n - w0, wr_log[w0]); end
    send_byte(8'h55); send_byte(8'hA5);
    tick(60);
    checks++; if (ferr_n !== e0 + 4) begin failures++; $display("FAIL ferr_gap: got %0d expected 4", ferr_n - e0); end
    send_byte(8'h10); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'hF0);
    tick(6);
    checks++; if (wr_n !== w0 + 1 || busy !== 1'b0) begin failures++; $display("FAIL ferr_gap_drop: wr=%0d busy=%b expected 1 0", wr_n - w0, busy); end
    send_frame(80'h55A5000011223344_55F0);
    wait_idle(50, "ferr_after");
    checks++; if (arm_n !== a0 + 1 || arm_last !== 80'h55A5000011223344_55F0) begin
      failures++; $display("FAIL ferr_recover: arm=%0d data=%h expected 1 55a5000011223344 55f0", arm_n - a0, arm_last); end
  endtask

  task automatic test_back_to_back();
    int w0, o0, t0, v0, a_cyc, n;
    w0 = wr_n; o0 = ovr_n; t0 = to_n; v0 = viol_n;
    auto_i2c = 1'b0;
    send_frame(80'h55A5301100000000_00F0);
    tick(3);
    a_cyc = wr_cyc;
    checks++; if (wr_n !== w0 + 1 || wr_log[w0] !== 16'h3011) begin failures++; $display("FAIL b2b_first: wr=%0d pair=%h expected 1 3011", wr_n - w0, wr_log[w0]); end
    send_frame(80'h55A5312200000000_00F0);
    tick(2);
    checks++; if (ovr_n !== o0 || wr_n !== w0 + 1 || busy !== 1'b1) begin
      failures++; $display("FAIL b2b_buffered: ovr=%0d wr=%0d busy=%b expected 0 1 1", ovr_n - o0, wr_n - w0, busy); end
    send_frame(80'h55A5323300000000_00F0);
    tick(2);
    checks++; if (ovr_n !== o0 + 1) begin failures++; $display("FAIL b2b_overrun: got %0d expected 1", ovr_n - o0); end
    n = 0;
    while (to_n == t0 && n < 200) begin tick(1); n++; end
    checks++; if (to_n !== t0 + 1 || to_cyc - a_cyc !== 100) begin
      failures++; $display("FAIL b2b_timeout: count=%0d delay=%0d expected 1 100", to_n - t0, to_cyc - a_cyc); end
    tick(6);
    checks++; if (wr_n !== w0 + 2 || wr_log[w0+1] !== 16'h3122) begin failures++; $display("FAIL b2b_second: wr=%0d pair=%h expected 2 3122", wr_n - w0, wr_log[w0+1]); end
    wait_idle(200, "b2b");
    checks++; if (to_n !== t0 + 2 || wr_n !== w0 + 2 || viol_n !== v0) begin
      failures++; $display("FAIL b2b_drain: to=%0d wr=%0d viol=%0d expected 2 2 0", to_n - t0, wr_n - w0, viol_n - v0); end
    auto_i2c = 1'b1;
    send_frame(80'h55A5404400000000_00F0);
    wait_idle(100, "b2b_next");
    checks++; if (wr_n !== w0 + 3 || wr_log[w0+2] !== 16'h4044 || to_n !== t0 + 2) begin
      failures++; $display("FAIL b2b_next: wr=%0d pair=%h to=%0d expected 3 4044 2", wr_n - w0, wr_log[w0+2], to_n - t0); end
  endtask

  task automatic test_rst_en();
    int w0, a0, e0;
    w0 = wr_n; a0 = arm_n; e0 = ferr_n;
    auto_i2c = 1'b0;
    send_frame(80'h55A5505500000000_00F0);
    tick(3);
    checks++; if (wr_n !== w0 + 1 || busy !== 1'b1) begin failures++; $display("FAIL rst_setup: wr=%0d busy=%b expected 1 1", wr_n - w0, busy); end
    #2 Rst = 1'b1;
    #1;
    checks++; if ({busy, i2c_wr_req, i2c_reg_addr, i2c_wr_data} !== 18'd0 || arm_data !== 80'd0) begin
      failures++; $display("FAIL rst_async: busy=%b req=%b i2c=%h expected 0 0 0000", busy, i2c_wr_req, {i2c_reg_addr, i2c_wr_data}); end
    tick(2);
    @(negedge Clk); Rst = 1'b0;
    auto_i2c = 1'b1;
    tick(20);
    checks++; if (wr_n !== w0 + 1 || busy !== 1'b0 || to_n < 0) begin failures++; $display("FAIL rst_no_reissue: wr=%0d busy=%b expected 1 0", wr_n - w0, busy); end
    EN = 1'b0;
    send_frame(80'h55A5606600000000_00F0);
    tick(10);
    checks++; if (wr_n !== w0 + 1 || arm_n !== a0 || busy !== 1'b0 || ferr_n !== e0) begin
      failures++; $display("FAIL en_drop: wr=%0d arm=%0d busy=%b ferr=%0d expected 1 0 0 0", wr_n - w0, arm_n - a0, busy, ferr_n - e0); end
    EN = 1'b1;
    send_frame(80'h55A5707700000000_00F0);
    wait_idle(100, "restart");
    checks++; if (wr_n !== w0 + 2 || wr_log[w0+1] !== 16'h7077) begin failures++; $display("FAIL restart: wr=%0d pair=%h expected 2 7077", wr_n - w0, wr_log[w0+1]); end
    send_frame(80'h55A5000001000000_00F0);
    tick(3);
    EN = 1'b0;
    wait_idle(50, "en_inflight");
    checks++; if (arm_n !== a0 + 1) begin failures++; $display("FAIL en_inflight: arm=%0d expected 1", arm_n - a0); end
    EN = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_arm();
    test_motor();
    test_skip();
    test_frame_err();
    test_back_to_back();
    test_rst_en();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
